// File: rtl/inst_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_prefetch_queue
// Purpose  : Instruction fetch front-end. Owns the fetch PC, reads a
//            combinational ROM and buffers {inst, pc} pairs for decode.
// Revision : 1.0 - initial release
// ============================================================================
module inst_prefetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       o_rom_ce,
    output logic [ADDR_W-1:0]          o_rom_addr,
    input  logic [INST_W-1:0]          i_rom_data,
    input  logic                       i_redirect,
    input  logic [ADDR_W-1:0]          i_redirect_pc,
    output logic                       o_inst_valid,
    output logic [INST_W-1:0]          o_inst,
    output logic [ADDR_W-1:0]          o_inst_pc,
    input  logic                       i_inst_ready,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int                 c_ptr_w      = $clog2(DEPTH);
    localparam int                 c_cnt_w      = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth      = c_cnt_w'(DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_one    = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [ADDR_W-1:0]  c_pc_step    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0]  c_align_mask = ~ADDR_W'(3);

    logic                r_run;
    logic [ADDR_W-1:0]   r_fetch_pc;
    logic [c_cnt_w-1:0]  r_count;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [INST_W-1:0]   r_mem_inst [DEPTH];
    logic [ADDR_W-1:0]   r_mem_pc   [DEPTH];

    logic                w_push;
    logic                w_pop;
    logic [ADDR_W-1:0]   w_redirect_pc;

    // Fetch enable depends only on registered state, so the ROM address
    // path never sees a combinational loop through decode's ready.
    assign o_rom_ce      = r_run && (r_count < c_depth);
    assign o_rom_addr    = r_fetch_pc;
    assign o_inst_valid  = (r_count != '0);
    assign o_inst        = r_mem_inst[r_rd_ptr];
    assign o_inst_pc     = r_mem_pc[r_rd_ptr];
    assign o_count       = r_count;

    assign w_push        = o_rom_ce && !i_redirect;
    assign w_pop         = o_inst_valid && i_inst_ready && !i_redirect;
    assign w_redirect_pc = i_redirect_pc & c_align_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (i_redirect) begin
            r_fetch_pc <= w_redirect_pc;
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + c_pc_step;
        end
    end

    // Redirect discards everything in flight, including this cycle's ROM word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (i_redirect) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_inst[i] <= '0;
                r_mem_pc[i]   <= '0;
            end
        end else if (w_push) begin
            r_mem_inst[r_wr_ptr] <= i_rom_data;
            r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_prefetch_queue
// Purpose  : Directed + randomized check of inst_prefetch_queue against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_prefetch_queue;

    localparam int c_depth = 4;

    logic        clk;
    logic        rst;
    logic        o_rom_ce;
    logic [31:0] o_rom_addr;
    logic [31:0] i_rom_data;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        i_inst_ready;
    logic [2:0]  o_count;

    inst_prefetch_queue #(
        .DEPTH    (c_depth),
        .ADDR_W   (32),
        .INST_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .o_rom_ce      (o_rom_ce),
        .o_rom_addr    (o_rom_addr),
        .i_rom_data    (i_rom_data),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_inst_valid  (o_inst_valid),
        .o_inst        (o_inst),
        .o_inst_pc     (o_inst_pc),
        .i_inst_ready  (i_inst_ready),
        .o_count       (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: word index of the address.
    assign i_rom_data = o_rom_addr >> 2;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_fetch_pc;
    bit          m_run;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fetch_pc = 32'h0000_0000;
        m_run      = 1'b0;
    endtask

    task automatic check_outputs();
        check("inst_valid", o_inst_valid, m_q.size() != 0);
        check("count", o_count, m_q.size());
        check("rom_ce", o_rom_ce, m_run && (m_q.size() < c_depth));
        check("rom_addr", o_rom_addr, m_fetch_pc);
        if (m_q.size() != 0) begin
            check("inst", o_inst, m_q[0].inst);
            check("inst_pc", o_inst_pc, m_q[0].pc);
        end
    endtask

    task automatic check_reset_state();
        check("rst_valid", o_inst_valid, 1'b0);
        check("rst_ce", o_rom_ce, 1'b0);
        check("rst_count", o_count, 0);
        check("rst_addr", o_rom_addr, 32'h0000_0000);
        check("rst_inst", o_inst, 32'h0);
        check("rst_inst_pc", o_inst_pc, 32'h0);
    endtask

    // One clock: drive inputs at the falling edge, advance the model by the
    // rules of a fetch queue, then check after the next falling edge.
    task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy);
        bit   can_fetch;
        bit   take;
        ent_t e;
        i_redirect    = redir;
        i_redirect_pc = rpc;
        i_inst_ready  = rdy;
        if (redir) begin
            m_q.delete();
            m_fetch_pc = {rpc[31:2], 2'b00};
        end else begin
            can_fetch = m_run && (m_q.size() < c_depth);
            take      = (m_q.size() != 0) && rdy;
            if (take) void'(m_q.pop_front());
            if (can_fetch) begin
                e.inst = m_fetch_pc >> 2;
                e.pc   = m_fetch_pc;
                m_q.push_back(e);
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        m_run = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic reset_release();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_outputs();
    endtask

    initial begin
        int guard;
        rst           = 1'b1;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'h0;
        i_inst_ready  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_state();

        // Scenario 1: streaming from reset.
        reset_release();
        repeat (8) step(1'b0, 32'h0, 1'b1);

        // Scenario 2: fill with decode stalled, then drain.
        rst = 1'b1;
        @(negedge clk);
        reset_release();
        repeat (7) step(1'b0, 32'h0, 1'b0);
        check("full_addr", o_rom_addr, 32'h10);
        check("full_count", o_count, 4);
        repeat (8) step(1'b0, 32'h0, 1'b1);

        // Scenario 3/4/5: redirects, misaligned target, address wrap.
        step(1'b1, 32'h0000_0100, 1'b1);
        check("redir_valid", o_inst_valid, 1'b0);
        check("redir_addr", o_rom_addr, 32'h100);
        step(1'b0, 32'h0, 1'b1);
        check("redir_pc", o_inst_pc, 32'h100);
        repeat (3) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h0000_0103, 1'b0);
        check("align_addr", o_rom_addr, 32'h100);
        repeat (3) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'hFFFF_FFF8, 1'b1);
        repeat (6) step(1'b0, 32'h0, 1'b1);

        // Scenario 6: asynchronous reset mid-cycle with three entries held.
        step(1'b1, 32'h0000_0040, 1'b0);
        guard = 0;
        while (m_q.size() != 3 && guard < 10) begin
            step(1'b0, 32'h0, 1'b0);
            guard++;
        end
        check("pre_rst_count", o_count, 3);
        #2 rst = 1'b1;
        #1 check_reset_state();
        @(posedge clk);
        reset_release();
        repeat (6) step(1'b0, 32'h0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bit          r_redir;
            bit          r_rdy;
            logic [31:0] r_pc;
            r_redir = ($urandom_range(0, 15) == 0);
            r_rdy   = (i % 100 < 50) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
            r_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            step(r_redir, r_pc, r_rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
